// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bundle: redirect, instruction-memory and decoder handshakes
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic            im_gnt;
  logic            im_rvalid;
  logic [XLEN-1:0] im_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            misalign_fault;

  modport master (
    input  redirect_valid, redirect_pc, im_gnt, im_rvalid, im_rdata, inst_ready,
    output im_req, im_addr, inst_valid, inst, inst_pc, misalign_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, im_gnt, im_rvalid, im_rdata, inst_ready,
    input  im_req, im_addr, inst_valid, inst, inst_pc, misalign_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: owns the PC, one outstanding imem request, one-entry inst buffer
// Optional misaligned-redirect halt enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master fio
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_FULL = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            stale_q, stale_d;
  logic            pend_valid_q, pend_valid_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_bad;
  logic            pend_bad;
  logic            req_active;
  logic            enter_halt;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q, fault_d;

  assign redir_tgt = fio.redirect_pc;
  assign redir_bad = |fio.redirect_pc[1:0];
`else
  assign redir_tgt = {fio.redirect_pc[XLEN-1:2], 2'b00};
  assign redir_bad = 1'b0;
`endif

  assign pend_bad = |pend_pc_q[1:0];

  // stale_q in REQ means an abandoned response is still due; hold off the next request until it drains
  assign req_active = (state_q == S_REQ) && !stale_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    stale_d      = stale_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    enter_halt   = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    fault_d      = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (fio.redirect_valid) begin
          pc_d       = redir_tgt;
          enter_halt = redir_bad;
        end
      end
      S_REQ: begin
        if (stale_q && fio.im_rvalid) begin
          stale_d = 1'b0;
        end
        if (req_active && fio.im_gnt) begin
          state_d      = S_WAIT;
          pend_valid_d = 1'b0;
          if (fio.redirect_valid) begin
            stale_d    = 1'b1;
            pc_d       = redir_tgt;
            enter_halt = redir_bad;
          end else if (pend_valid_q) begin
            stale_d    = 1'b1;
            pc_d       = pend_pc_q;
            enter_halt = pend_bad;
          end
        end else if (fio.redirect_valid) begin
          // address is frozen until the grant; the target waits here
          pend_valid_d = 1'b1;
          pend_pc_d    = redir_tgt;
        end
      end
      S_WAIT: begin
        if (fio.redirect_valid) begin
          pc_d       = redir_tgt;
          enter_halt = redir_bad;
          if (fio.im_rvalid) begin
            stale_d = 1'b0;
            state_d = S_REQ;
          end else begin
            stale_d = 1'b1;
          end
        end else if (fio.im_rvalid) begin
          if (stale_q) begin
            stale_d = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d       = fio.im_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (fio.redirect_valid) begin
          inst_valid_d = 1'b0;
          pc_d         = redir_tgt;
          state_d      = S_REQ;
          enter_halt   = redir_bad;
        end else if (fio.inst_ready) begin
          inst_valid_d = 1'b0;
          pc_d         = pc_q + XLEN'(4);
          state_d      = S_REQ;
        end
      end
`ifdef FETCH_MISALIGN_CHK_EN
      S_HALT: begin
        if (fio.im_rvalid) begin
          stale_d = 1'b0;
        end
        if (fio.redirect_valid) begin
          pc_d = redir_tgt;
          if (redir_bad) begin
            enter_halt = 1'b1;
          end else begin
            fault_d = 1'b0;
            state_d = S_REQ;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (enter_halt) begin
      state_d      = S_HALT;
      inst_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_d      = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      pend_valid_q <= 1'b0;
      stale_q      <= 1'b0;
      inst_q       <= NOP;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      stale_q      <= stale_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fio.misalign_fault = fault_q;
`else
  assign fio.misalign_fault = 1'b0;
`endif

  assign fio.im_req     = req_active;
  assign fio.im_addr    = pc_q;
  assign fio.inst_valid = inst_valid_q;
  assign fio.inst       = inst_q;
  assign fio.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a transaction-level model
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) fio();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fio   (fio)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // memory contents: every word holds its own address plus one
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a + 32'd1;
  endfunction

  function automatic logic [31:0] model_tgt(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  int gnt_pct, rdy_pct, redir_pct, dly_min, dly_max;
  int arm_mode;
  logic [31:0] arm_tgt;
  bit arm_dead;
  int gnt_block, rdy_block;
  logic [31:0] watch_addr;
  int watch_req, watch_pres;
  bit await_req;
  logic [31:0] next_req_addr;
  int dead_seen, overlap, n_present, cyc;

  logic [31:0] exp_pc;
  bit prev_req, prev_gnt, prev_redir, prev_valid, prev_consume;
  logic [31:0] prev_addr, prev_inst, prev_inst_pc;

  bit outstanding;
  int resp_cnt;
  logic [31:0] resp_data;

  int valid_k[$];
  logic [31:0] req_log[$];

  task automatic cycle();
    bit redir, gnt, rdy, rv, consume;
    int fired;
    logic [31:0] tgt, rd;
    @(posedge clk);
    #1;
    cyc++;

    if (prev_req && !prev_gnt) begin
      check_eq("req_hold", 32'(fio.im_req), 32'd1);
      check_eq("addr_hold", fio.im_addr, prev_addr);
    end
    if (prev_redir) check_eq("valid_after_redirect", 32'(fio.inst_valid), 32'd0);
    if (outstanding) check_eq("single_outstanding", 32'(fio.im_req), 32'd0);
    if (fio.inst_valid) begin
      if (prev_valid && !prev_consume && !prev_redir) begin
        check_eq("inst_hold", fio.inst, prev_inst);
        check_eq("inst_pc_hold", fio.inst_pc, prev_inst_pc);
      end else begin
        check_eq("inst_pc", fio.inst_pc, exp_pc);
        check_eq("inst_data", fio.inst, mem_f(fio.inst_pc));
        n_present++;
        valid_k.push_back(cyc);
        if (fio.inst_pc == watch_addr) watch_pres++;
      end
      if (fio.inst == 32'hDEAD) dead_seen++;
      if (fio.im_req) overlap++;
    end
`ifndef FETCH_MISALIGN_CHK_EN
    check_eq("fault_tied_low", 32'(fio.misalign_fault), 32'd0);
`endif
    if (fio.im_req) begin
      req_log.push_back(fio.im_addr);
      if (fio.im_addr == watch_addr) watch_req++;
      if (await_req) begin
        next_req_addr = fio.im_addr;
        await_req     = 1'b0;
      end
    end

    rv = 1'b0;
    rd = '0;
    if (outstanding) begin
      resp_cnt--;
      if (resp_cnt <= 0) begin
        rv          = 1'b1;
        rd          = resp_data;
        outstanding = 1'b0;
      end
    end

    redir = 1'b0;
    tgt   = '0;
    fired = 0;
    case (arm_mode)
      1: if (outstanding && prev_gnt) begin
           redir = 1'b1;
           if (arm_dead) resp_data = 32'hDEAD;
         end
      2: if (fio.inst_valid) redir = 1'b1;
      3: redir = 1'b1;
      default: if (int'($urandom_range(99)) < redir_pct) begin
        redir = 1'b1;
        tgt   = 32'($urandom_range(1023));
`ifdef FETCH_MISALIGN_CHK_EN
        tgt[1:0] = 2'b00;
`endif
      end
    endcase
    if (arm_mode != 0 && redir) begin
      tgt      = arm_tgt;
      fired    = arm_mode;
      arm_mode = 0;
    end
    if (redir) await_req = 1'b1;

    gnt = 1'b0;
    if (fio.im_req) begin
      if (gnt_block > 0 && fio.im_addr == watch_addr) gnt_block--;
      else gnt = int'($urandom_range(99)) < gnt_pct;
    end
    if (gnt) begin
      outstanding = 1'b1;
      resp_cnt    = int'($urandom_range(dly_max, dly_min));
      resp_data   = mem_f(fio.im_addr);
    end

    if (rdy_block > 0 && fio.inst_valid) begin
      rdy = 1'b0;
      rdy_block--;
    end else begin
      rdy = int'($urandom_range(99)) < rdy_pct;
    end
    if (fired == 2) rdy = 1'b1;

    consume = fio.inst_valid && rdy && !redir;
    if (redir) exp_pc = model_tgt(tgt);
    else if (consume) exp_pc = fio.inst_pc + 32'd4;

    prev_req     = fio.im_req;
    prev_gnt     = gnt;
    prev_addr    = fio.im_addr;
    prev_redir   = redir;
    prev_valid   = fio.inst_valid;
    prev_inst    = fio.inst;
    prev_inst_pc = fio.inst_pc;
    prev_consume = consume;

    fio.redirect_valid = redir;
    fio.redirect_pc    = tgt;
    fio.im_gnt         = gnt;
    fio.im_rvalid      = rv;
    fio.im_rdata       = rd;
    fio.inst_ready     = rdy;
  endtask

  task automatic do_reset(input bit late_rvalid);
    rst_n              = 1'b0;
    fio.redirect_valid = 1'b0;
    fio.redirect_pc    = '0;
    fio.im_gnt         = 1'b0;
    fio.im_rvalid      = 1'b0;
    fio.im_rdata       = '0;
    fio.inst_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_im_req", 32'(fio.im_req), 32'd0);
    check_eq("rst_im_addr", fio.im_addr, RESET_PC);
    check_eq("rst_inst_valid", 32'(fio.inst_valid), 32'd0);
    check_eq("rst_inst", fio.inst, 32'h0000_0013);
    check_eq("rst_inst_pc", fio.inst_pc, RESET_PC);
    check_eq("rst_fault", 32'(fio.misalign_fault), 32'd0);
    exp_pc        = RESET_PC;
    prev_req      = 1'b0;
    prev_gnt      = 1'b0;
    prev_redir    = 1'b0;
    prev_valid    = 1'b0;
    prev_consume  = 1'b0;
    prev_addr     = '0;
    prev_inst     = '0;
    prev_inst_pc  = '0;
    outstanding   = 1'b0;
    resp_cnt      = 0;
    await_req     = 1'b0;
    next_req_addr = 32'hFFFF_FFFF;
    arm_mode      = 0;
    arm_dead      = 1'b0;
    gnt_block     = 0;
    rdy_block     = 0;
    watch_req     = 0;
    watch_pres    = 0;
    dead_seen     = 0;
    overlap       = 0;
    cyc           = 0;
    valid_k.delete();
    req_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
    if (late_rvalid) begin
      fio.im_rvalid = 1'b1;
      fio.im_rdata  = 32'hBAD0;
    end
  endtask

  initial begin
    gnt_pct    = 100;
    rdy_pct    = 100;
    redir_pct  = 0;
    dly_min    = 1;
    dly_max    = 1;
    watch_addr = 32'hFFFF_FFFF;
    n_present  = 0;

    // zero-wait memory, decoder always ready
    do_reset(1'b0);
    repeat (10) cycle();
    for (int i = 0; i < 3; i++) begin
      check_eq("zw_addr", (req_log.size() > i) ? req_log[i] : 32'hFFFF_FFFF, 32'(4 * i));
      check_eq("zw_valid_cycle", (valid_k.size() > i) ? 32'(valid_k[i]) : 32'hFFFF_FFFF, 32'(3 * (i + 1)));
    end

    // grant withheld for four cycles on the second fetch
    do_reset(1'b0);
    watch_addr = 32'h4;
    gnt_block  = 4;
    repeat (14) cycle();
    check_eq("gnt_stall_req_cycles", 32'(watch_req), 32'd5);
    check_eq("gnt_stall_single_fetch", 32'(watch_pres), 32'd1);

    // decoder stalls five cycles on the first instruction
    do_reset(1'b0);
    watch_addr = 32'hFFFF_FFFF;
    rdy_block  = 5;
    repeat (14) cycle();
    check_eq("full_stall_no_req", 32'(overlap), 32'd0);
    check_eq("full_stall_second_valid", (valid_k.size() > 1) ? 32'(valid_k[1]) : 32'hFFFF_FFFF, 32'd11);

    // redirect while waiting; the late response carries 0xDEAD
    do_reset(1'b0);
    dly_min    = 3;
    dly_max    = 3;
    arm_mode   = 1;
    arm_tgt    = 32'h100;
    arm_dead   = 1'b1;
    watch_addr = 32'h100;
    repeat (20) cycle();
    check_eq("wait_redirect_dead_shown", 32'(dead_seen), 32'd0);
    check_eq("wait_redirect_next_addr", next_req_addr, 32'h100);
    check_eq("wait_redirect_fetched", 32'(watch_pres > 0), 32'd1);

    // redirect in the same cycle the decoder accepts
    do_reset(1'b0);
    dly_min    = 1;
    dly_max    = 1;
    arm_mode   = 2;
    arm_tgt    = 32'h200;
    watch_addr = 32'h4;
    repeat (12) cycle();
    check_eq("full_redirect_next_addr", next_req_addr, 32'h200);
    check_eq("full_redirect_no_seq_fetch", 32'(watch_req), 32'd0);

    // misaligned redirect target
    do_reset(1'b0);
    arm_mode = 2;
    arm_tgt  = 32'h102;
    for (int i = 0; i < 6 && arm_mode != 0; i++) cycle();
    check_eq("misalign_redirect_issued", 32'(arm_mode), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("halt_fault", 32'(fio.misalign_fault), 32'd1);
      check_eq("halt_no_req", 32'(fio.im_req), 32'd0);
    end
    arm_mode = 3;
    arm_tgt  = 32'h104;
    repeat (3) cycle();
    check_eq("halt_exit_fault", 32'(fio.misalign_fault), 32'd0);
    check_eq("halt_exit_addr", next_req_addr, 32'h104);
`else
    repeat (3) cycle();
    check_eq("misalign_forced_addr", next_req_addr, 32'h100);
`endif

    // sequential PC wraps past the top of the address space
    do_reset(1'b0);
    arm_mode = 2;
    arm_tgt  = 32'hFFFF_FFFC;
    repeat (4) cycle();
    watch_addr = 32'h0;
    watch_pres = 0;
    repeat (8) cycle();
    check_eq("pc_wrap_fetch_zero", 32'(watch_pres), 32'd1);

    // reset abandons an outstanding fetch; late rvalid lands in IDLE
    do_reset(1'b0);
    dly_min    = 3;
    dly_max    = 3;
    watch_addr = 32'hFFFF_FFFF;
    repeat (2) cycle();
    do_reset(1'b1);
    dly_min = 1;
    dly_max = 1;
    repeat (6) cycle();
    check_eq("late_rvalid_first_valid", (valid_k.size() > 0) ? 32'(valid_k[0]) : 32'hFFFF_FFFF, 32'd3);

    // randomized traffic against the model
    do_reset(1'b0);
    gnt_pct   = 60;
    rdy_pct   = 60;
    redir_pct = 4;
    dly_min   = 1;
    dly_max   = 3;
    n_present = 0;
    repeat (3000) cycle();
    check_eq("random_progress", 32'(n_present >= 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder/controller.
- Owns the architectural PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers one returned instruction and presents it to the decoder with a valid/ready handshake.
- Accepts PC redirects for taken branches and jumps, and discards stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, PC, address and instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  taken branch or jump; load redirect_pc.
- redirect_pc  in  XLEN  redirect target.
- im_req  out  1  instruction memory request.
- im_addr  out  XLEN  request address (PC).
- im_gnt  in  1  memory accepted the request this cycle.
- im_rvalid  in  1  read data valid.
- im_rdata  in  XLEN  read data.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst_ready  in  1  decoder consumes the instruction.
- inst  out  XLEN  fetched instruction.
- inst_pc  out  XLEN  PC of inst.
- misalign_fault  out  1  misaligned redirect flag (optional feature).

Behaviour:
- Reset (async assert, sync deassert use):
  - pc_q = RESET_PC, state = IDLE, stale flag = 0.
  - im_req = 0, im_addr = RESET_PC, inst_valid = 0, inst = 32'h0000_0013 (NOP), inst_pc = RESET_PC, misalign_fault = 0.
- States:
  - IDLE: single cycle after reset. No request. Goes to REQ.
  - REQ: im_req = 1, im_addr = pc_q. On im_gnt go to WAIT.
  - WAIT: one request outstanding. On im_rvalid, register im_rdata into inst and pc_q into inst_pc, set inst_valid, go to FULL.
  - FULL: hold inst, inst_pc and inst_valid stable while inst_ready = 0. On inst_ready: pc_q += 4 (mod 2^XLEN, wraps silently), inst_valid = 0, go to REQ.
- Latency:
  - gnt -> earliest rvalid is the next cycle; inst_valid rises the cycle after rvalid.
  - Peak throughput is one instruction per 3 cycles with zero-wait memory.
- Request stability: once im_req = 1, im_req and im_addr must not change until im_gnt, including when a redirect arrives.
- Only one outstanding request. im_rvalid outside WAIT is ignored.
- Redirect handling (redirect has priority over every other event in the same cycle):
  - IDLE: pc_q <= redirect_pc.
  - REQ without gnt: store redirect_pc as pending and keep the request stable. At gnt, set stale; pc_q <= pending.
  - REQ with gnt in the same cycle: set stale; pc_q <= redirect_pc; go to WAIT.
  - WAIT: set stale; pc_q <= redirect_pc. When rvalid arrives, discard it (inst_valid stays 0), clear stale, go to REQ. rvalid in the same cycle as the redirect is also discarded.
  - FULL: inst_valid <= 0 next cycle even if inst_ready = 1. pc_q <= redirect_pc; go to REQ.
  - A second redirect while stale overwrites pc_q. Only the last redirect is honoured.
- Reset mid-transaction: the outstanding request is abandoned. A late rvalid arrives in IDLE and is ignored.

Optional Feature:
- FETCH_MISALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0] != 2'b00 goes to a HALT state: no requests, inst_valid = 0, misalign_fault = 1.
  - HALT is left only on an aligned redirect, which clears misalign_fault and goes to REQ. Reset also clears it.
- Not defined:
  - redirect_pc[1:0] is forced to 2'b00.
  - misalign_fault is tied to 0; the HALT state is not generated.

Test Plan:
- Reset release, zero-wait memory returning addr+1, inst_ready = 1 -> im_addr sequence 0x0, 0x4, 0x8; inst_pc matches; inst_valid every 3rd cycle.
- im_gnt held low 4 cycles -> im_req and im_addr = 0x4 stable all 4 cycles; a single fetch follows.
- FULL with inst_ready = 0 for 5 cycles -> inst and inst_pc unchanged, no new im_req.
- Redirect to 0x100 in WAIT, rvalid 2 cycles later with 0xDEAD -> 0xDEAD is never presented; next im_addr = 0x100.
- Redirect to 0x200 in the same cycle as FULL and inst_ready -> inst_valid = 0 next cycle; next im_addr = 0x200, not pc+4.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x102 -> misalign_fault = 1, im_req = 0; then redirect to 0x104 -> fault cleared, im_addr = 0x104.
